adc_frontend_cal: RTL and testbench
===================================

ADC_FRONTEND_CAL -- requirements
Module: adc_frontend_cal

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of ADC channels.
REQ-002 SHALL have parameter ADC_WIDTH, default 14: width of raw samples and outputs.
REQ-003 SHALL have parameter GAIN_WIDTH, default 8: unsigned per-channel gain width.
REQ-004 SHALL have parameter GAIN_FRAC, default 6: gain fractional bits, so gain 64 = 1.0.
REQ-005 SHALL have parameter OFFSET_DEFAULT, default 8192: offset value loaded at reset.
REQ-006 SHALL have parameter MAX_DELAY, default 32: loopback delay-line depth.
REQ-007 SHALL have parameter CAL_LOG2, default 10: calibration averages 2^CAL_LOG2 samples.
REQ-008 SHALL have parameter SETTLE_CYCLES, default 16: calibration settle time in cycles.
REQ-009 SHALL have port clk125  in  1: single clock; all logic is on its rising edge.
REQ-010 SHALL have port reset_n  in  1: reset, synchronous and active-low.
REQ-011 SHALL have port adc_raw  in  NUM_CH*ADC_WIDTH: unsigned offset-binary samples, asynchronous to clk125.
REQ-012 SHALL have port dac_ref  in  ADC_WIDTH: signed loopback source (DAC drive word).
REQ-013 SHALL have port loop_sel  in  NUM_CH: per channel, 1 = output delayed dac_ref instead of ADC.
REQ-014 SHALL have port delay  in  clog2(MAX_DELAY): loopback tap select.
REQ-015 SHALL have port gain  in  NUM_CH*GAIN_WIDTH: per-channel unsigned gain.
REQ-016 SHALL have port cal_start  in  1: level request to start offset calibration.
REQ-017 SHALL have port cal_busy  out  1: high while calibration is running.
REQ-018 SHALL have port cal_done  out  1: one-cycle pulse when a new offset is applied.
REQ-019 SHALL have port offset_out  out  NUM_CH*ADC_WIDTH: current per-channel offsets.
REQ-020 SHALL have port data_out  out  NUM_CH*ADC_WIDTH: signed corrected samples.
REQ-021 SHALL have port data_valid  out  1: data_out is meaningful.
REQ-022 SHALL have port sat_flag  out  NUM_CH: per channel, data_out was clamped this cycle.

Function
REQ-023 SHALL pass each adc_raw channel through a 2-flop synchronizer before any use.
REQ-024 SHALL use this ADC path per channel: stage 3 computes diff = sync - offset (signed, ADC_WIDTH+1); stage 4 computes prod = diff*gain (full width); stage 5 saturates prod>>>GAIN_FRAC (arithmetic) to ADC_WIDTH signed.
REQ-025 SHALL give a latency of exactly 5 clk125 cycles from adc_raw to data_out.
REQ-026 SHALL clamp to [-2^(ADC_WIDTH-1), 2^(ADC_WIDTH-1)-1], with sat_flag registered in the same cycle as the clamped data_out.
REQ-027 SHALL implement the loopback as a shared MAX_DELAY-deep shift register of dac_ref; tap index = delay; dac_ref reaches data_out delay+1 cycles later; gain and offset are bypassed; sat_flag=0.
REQ-028 SHALL apply changes to loop_sel, delay or gain on the next output; the delay line is never flushed except at reset.
REQ-029 SHALL use calibration FSM states IDLE, SETTLE, ACCUM, APPLY.
REQ-030 SHALL transition IDLE->SETTLE when cal_start=1.
REQ-031 SHALL stay in SETTLE for SETTLE_CYCLES cycles, then go to ACCUM.
REQ-032 SHALL, in ACCUM, sum 2^CAL_LOG2 synchronized samples per channel into (ADC_WIDTH+CAL_LOG2)-bit accumulators cleared on entry, then go to APPLY.
REQ-033 SHALL, in APPLY, set offset = acc>>CAL_LOG2 (truncate), pulse cal_done, and return to IDLE.
REQ-034 SHALL hold cal_busy=1 in SETTLE, ACCUM and APPLY; busy lasts SETTLE_CYCLES+2^CAL_LOG2+1 cycles.
REQ-035 SHALL ignore cal_start outside IDLE; cal_start held high re-triggers calibration from IDLE.
REQ-036 SHALL drive data_valid=0 while cal_busy and for 3 cycles after APPLY (pipeline refill with new offset); loopback channels follow the same data_valid.
REQ-037 SHALL drive data_valid=0 for 5 cycles after reset release, then 1.

Reset
REQ-038 SHALL, on reset_n=0 at a clock edge, set data_out=0, sat_flag=0, data_valid=0, cal_busy=0, cal_done=0, offset=OFFSET_DEFAULT, and clear all pipeline, synchronizer and delay-line registers and accumulators, with FSM=IDLE.
REQ-039 SHALL abort a calibration on reset mid-operation, with no cal_done and the offset restored to OFFSET_DEFAULT.

Verification
REQ-040 SHALL pass this scenario: after reset, gain=64, adc_raw=8292 both channels -> data_out=100 exactly 5 cycles later, data_valid=1 from cycle 5, sat_flag=0.
REQ-041 SHALL pass this scenario: gain=128, adc_raw=13192 -> data_out=8191, sat_flag=1; adc_raw=0 -> data_out=-8192, sat_flag=1.
REQ-042 SHALL pass this scenario: CAL_LOG2=4, SETTLE_CYCLES=4, adc_raw constant 8200, cal_start pulse -> cal_busy high 21 cycles, single cal_done, offset_out=8200, then data_out=0 with data_valid=1 after 3-cycle refill.
REQ-043 SHALL pass this scenario: loop_sel=01, delay=19, one-cycle dac_ref=1000 impulse -> ch0 data_out=1000 exactly 20 cycles later for one cycle; ch1 keeps ADC data.
REQ-044 SHALL pass this scenario: reset_n low on cycle 8 of ACCUM, plus cal_start re-asserted during ACCUM beforehand -> cal_start ignored, cal_busy=0, offset_out=8192, no cal_done.

Source files
------------

// File: rtl/adc_frontend_cal.sv
// ADC front end: input synchronizer, offset/gain correction with saturation,
// DAC loopback delay line and an averaging offset-calibration state machine.
module adc_frontend_cal #(
    parameter int NUM_CH         = 2,
    parameter int ADC_WIDTH      = 14,
    parameter int GAIN_WIDTH     = 8,
    parameter int GAIN_FRAC      = 6,
    parameter int OFFSET_DEFAULT = 8192,
    parameter int MAX_DELAY      = 32,
    parameter int CAL_LOG2       = 10,
    parameter int SETTLE_CYCLES  = 16
) (
    input  logic                             clk125,
    input  logic                             reset_n,
    input  logic [NUM_CH*ADC_WIDTH-1:0]      adc_raw,
    input  logic [ADC_WIDTH-1:0]             dac_ref,
    input  logic [NUM_CH-1:0]                loop_sel,
    input  logic [$clog2(MAX_DELAY)-1:0]     delay,
    input  logic [NUM_CH*GAIN_WIDTH-1:0]     gain,
    input  logic                             cal_start,
    output logic                             cal_busy,
    output logic                             cal_done,
    output logic [NUM_CH*ADC_WIDTH-1:0]      offset_out,
    output logic [NUM_CH*ADC_WIDTH-1:0]      data_out,
    output logic                             data_valid,
    output logic [NUM_CH-1:0]                sat_flag
);
    localparam int W       = ADC_WIDTH;
    localparam int G       = GAIN_WIDTH;
    localparam int DIFF_W  = W + 1;
    localparam int PROD_W  = W + G + 1;
    localparam int ACC_W   = W + CAL_LOG2;
    localparam int NSAMP   = 1 << CAL_LOG2;
    localparam int CNT_MAX = (SETTLE_CYCLES > NSAMP) ? SETTLE_CYCLES : NSAMP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(1 << (W - 1)));

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, APPLY} cal_state_e;

    logic [W-1:0]              sync1_q [NUM_CH];
    logic [W-1:0]              sync1_d [NUM_CH];
    logic [W-1:0]              sync2_q [NUM_CH];
    logic [W-1:0]              sync2_d [NUM_CH];
    logic signed [DIFF_W-1:0]  diff_q  [NUM_CH];
    logic signed [DIFF_W-1:0]  diff_d  [NUM_CH];
    logic signed [PROD_W-1:0]  prod_q  [NUM_CH];
    logic signed [PROD_W-1:0]  prod_d  [NUM_CH];
    logic [W-1:0]              data_q  [NUM_CH];
    logic [W-1:0]              data_d  [NUM_CH];
    logic [NUM_CH-1:0]         sat_q;
    logic [NUM_CH-1:0]         sat_d;
    logic [W-1:0]              dly_q   [MAX_DELAY-1];
    logic [W-1:0]              dly_d   [MAX_DELAY-1];
    logic [W-1:0]              tap;

    cal_state_e                state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [ACC_W-1:0]          acc_q    [NUM_CH];
    logic [W-1:0]              offset_q [NUM_CH];
    logic                      busy_q;
    logic                      done_q;
    logic                      valid_q;
    logic [2:0]                hold_q;

    // Tap 0 is dac_ref itself so that the output register makes it delay+1 cycles.
    always_comb begin
        tap = dac_ref;
        for (int i = 1; i < MAX_DELAY; i++) begin
            if (int'(delay) == i) tap = dly_q[i-1];
        end
        dly_d[0] = dac_ref;
        for (int i = 1; i < MAX_DELAY - 1; i++) dly_d[i] = dly_q[i-1];
    end

    always_comb begin : ch_path
        logic signed [PROD_W-1:0] scaled;
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        scaled = '0;
        sat_d  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sync1_d[c] = adc_raw[c*W +: W];
            sync2_d[c] = sync1_q[c];
            diff_d[c]  = $signed({1'b0, sync2_q[c]}) - $signed({1'b0, offset_q[c]});
            prod_d[c]  = PROD_W'(diff_q[c]) * PROD_W'($signed({1'b0, gain[c*G +: G]}));
            scaled     = prod_q[c] >>> GAIN_FRAC;
            if (loop_sel[c]) begin
                data_d[c] = tap;
            end else if (scaled > SAT_MAX) begin
                data_d[c] = SAT_MAX[W-1:0];
                sat_d[c]  = 1'b1;
            end else if (scaled < SAT_MIN) begin
                data_d[c] = SAT_MIN[W-1:0];
                sat_d[c]  = 1'b1;
            end else begin
                data_d[c] = scaled[W-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk125) begin
        if (!reset_n) begin
            sync1_q <= '{default: '0};
            sync2_q <= '{default: '0};
            diff_q  <= '{default: '0};
            prod_q  <= '{default: '0};
            data_q  <= '{default: '0};
            sat_q   <= '0;
            // NOTE: the delay line is an array but must still be cleared, so it sits in flops, not RAM.
            dly_q   <= '{default: '0};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            diff_q  <= diff_d;
            prod_q  <= prod_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
            dly_q   <= dly_d;
        end
    end

    // hold_q counts the cycles the pipeline still carries stale data.
    always_ff @(posedge clk125) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '{default: '0};
            offset_q <= '{default: W'(OFFSET_DEFAULT)};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            hold_q   <= 3'd4;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cal_start) begin
                        state_q <= SETTLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                    end else if (hold_q != 3'd0) begin
                        hold_q  <= hold_q - 3'd1;
                        valid_q <= 1'b0;
                    end else begin
                        valid_q <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state_q <= ACCUM;
                        cnt_q   <= '0;
                        acc_q   <= '{default: '0};
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ACCUM: begin
                    for (int c = 0; c < NUM_CH; c++) acc_q[c] <= acc_q[c] + ACC_W'(sync2_q[c]);
                    if (cnt_q == CNT_W'(NSAMP - 1)) state_q <= APPLY;
                    else                            cnt_q   <= cnt_q + 1'b1;
                end
                APPLY: begin
                    for (int c = 0; c < NUM_CH; c++) offset_q[c] <= acc_q[c][ACC_W-1:CAL_LOG2];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    hold_q  <= 3'd2;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        data_out   = '0;
        offset_out = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            data_out[c*W +: W]   = data_q[c];
            offset_out[c*W +: W] = offset_q[c];
        end
    end

    assign sat_flag   = sat_q;
    assign cal_busy   = busy_q;
    assign cal_done   = done_q;
    assign data_valid = valid_q;

endmodule

// File: tb/tb_adc_frontend_cal.sv
// Bench for adc_frontend_cal: reset, correction vectors, streamed scoreboard,
// loopback, calibration, reset abort and calibration retrigger.
module tb_adc_frontend_cal;
    typedef struct { int raw; int g; int exp_d; bit exp_s; } vec_t;
    typedef struct { int due; int d0; int d1; bit s0; bit s1; } sb_t;

    logic        clk125 = 1'b0;
    logic        reset_n;
    logic [27:0] adc_raw;
    logic [13:0] dac_ref;
    logic [1:0]  loop_sel;
    logic [4:0]  delay;
    logic [15:0] gain;
    logic        cal_start;
    logic        cal_busy;
    logic        cal_done;
    logic [27:0] offset_out;
    logic [27:0] data_out;
    logic        data_valid;
    logic [1:0]  sat_flag;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    sb_t  sb_q[$];
    vec_t vecs[12];
    bit   busy_a[48];
    bit   done_a[48];
    bit   valid_a[48];
    logic signed [31:0] d0_a[48];
    logic signed [31:0] d1_a[48];

    adc_frontend_cal #(.CAL_LOG2(4), .SETTLE_CYCLES(4)) dut (
        .clk125    (clk125),
        .reset_n   (reset_n),
        .adc_raw   (adc_raw),
        .dac_ref   (dac_ref),
        .loop_sel  (loop_sel),
        .delay     (delay),
        .gain      (gain),
        .cal_start (cal_start),
        .cal_busy  (cal_busy),
        .cal_done  (cal_done),
        .offset_out(offset_out),
        .data_out  (data_out),
        .data_valid(data_valid),
        .sat_flag  (sat_flag)
    );

    always #4 clk125 = ~clk125;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic signed [31:0] dout(input int ch);
        logic signed [13:0] t;
        t = data_out[ch*14 +: 14];
        return 32'(t);
    endfunction

    function automatic logic signed [31:0] offv(input int ch);
        return 32'(offset_out[ch*14 +: 14]);
    endfunction

    function automatic void model(input int raw, input int g, output int d, output bit s);
        int v;
        v = ((raw - 8192) * g) >>> 6;
        s = 1'b1;
        if (v > 8191)       d = 8191;
        else if (v < -8192) d = -8192;
        else begin d = v; s = 1'b0; end
    endfunction

    task automatic drive(input int r0, input int r1, input int g0, input int g1);
        adc_raw = {14'(r1), 14'(r0)};
        gain    = {8'(g1), 8'(g0)};
    endtask

    task automatic tick();
        sb_t e;
        @(posedge clk125);
        #1;
        cyc++;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            check("sb_latency", cyc, e.due);
            check("sb_data0", dout(0), e.d0);
            check("sb_data1", dout(1), e.d1);
            check("sb_sat0", 32'(sat_flag[0]), 32'(e.s0));
            check("sb_sat1", 32'(sat_flag[1]), 32'(e.s1));
            check("sb_valid", 32'(data_valid), 1);
        end
    endtask

    task automatic rec(input int j);
        busy_a[j]  = cal_busy;
        done_a[j]  = cal_done;
        valid_a[j] = data_valid;
        d0_a[j]    = dout(0);
        d1_a[j]    = dout(1);
    endtask

    initial begin
        int  k, busy_cnt, done_cnt, vld_cnt, e0, e1;
        bit  s0, s1;
        sb_t e;

        vecs[0]  = '{8292,  64,   100,  1'b0};
        vecs[1]  = '{13192, 128,  8191, 1'b1};
        vecs[2]  = '{0,     128, -8192, 1'b1};
        vecs[3]  = '{8092,  32,   -50,  1'b0};
        vecs[4]  = '{8193,  1,     0,   1'b0};
        vecs[5]  = '{8191,  1,    -1,   1'b0};
        vecs[6]  = '{16383, 64,   8191, 1'b0};
        vecs[7]  = '{0,     64,  -8192, 1'b0};
        vecs[8]  = '{16383, 65,   8191, 1'b1};
        vecs[9]  = '{12288, 255,  8191, 1'b1};
        vecs[10] = '{4096,  255, -8192, 1'b1};
        vecs[11] = '{8292,  0,     0,   1'b0};

        reset_n = 1'b0; dac_ref = '0; loop_sel = '0; delay = '0; cal_start = 1'b0;
        drive(8292, 8292, 64, 64);
        repeat (3) tick();
        check("rst_data0", dout(0), 0);
        check("rst_data1", dout(1), 0);
        check("rst_valid", 32'(data_valid), 0);
        check("rst_busy", 32'(cal_busy), 0);
        check("rst_done", 32'(cal_done), 0);
        check("rst_sat", 32'(sat_flag), 0);
        check("rst_off0", offv(0), 8192);
        check("rst_off1", offv(1), 8192);

        // First corrected sample appears exactly 5 cycles after release.
        reset_n = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            tick();
            if (j < 5) check("valid_before_5", 32'(data_valid), 0);
        end
        check("first_valid", 32'(data_valid), 1);
        check("first_data0", dout(0), 100);
        check("first_data1", dout(1), 100);
        check("first_sat", 32'(sat_flag), 0);

        for (int i = 0; i < 12; i++) begin
            vec_t a, b;
            a = vecs[i];
            b = vecs[(i + 5) % 12];
            drive(a.raw, b.raw, a.g, b.g);
            repeat (6) tick();
            check("vec_data0", dout(0), a.exp_d);
            check("vec_data1", dout(1), b.exp_d);
            check("vec_sat0", 32'(sat_flag[0]), 32'(a.exp_s));
            check("vec_sat1", 32'(sat_flag[1]), 32'(b.exp_s));
        end

        // Back-to-back samples through the scoreboard at fixed gains.
        drive(8192, 8192, 100, 37);
        repeat (6) tick();
        for (int i = 0; i < 40; i++) begin
            int r0, r1;
            r0 = int'($urandom_range(0, 16383));
            r1 = int'($urandom_range(0, 16383));
            drive(r0, r1, 100, 37);
            model(r0, 100, e0, s0);
            model(r1, 37, e1, s1);
            e = '{cyc + 5, e0, e1, s0, s1};
            sb_q.push_back(e);
            tick();
        end
        repeat (6) tick();
        check("sb_drained", sb_q.size(), 0);

        // Loopback on ch0 bypasses gain/offset; ch1 stays on the ADC path.
        drive(13192, 8292, 128, 64);
        loop_sel = 2'b01;
        delay    = 5'd19;
        repeat (6) tick();
        check("loop_idle0", dout(0), 0);
        check("loop_idle_sat0", 32'(sat_flag[0]), 0);
        check("loop_adc1", dout(1), 100);
        k = cyc;
        dac_ref = 14'd1000;
        tick();
        dac_ref = '0;
        check("loop_imp", dout(0), 0);
        for (int j = 2; j <= 22; j++) begin
            tick();
            check("loop_imp", dout(0), (cyc - k == 20) ? 1000 : 0);
        end
        check("loop_ch1_kept", dout(1), 100);
        check("loop_valid", 32'(data_valid), 1);
        delay   = 5'd0;
        dac_ref = 14'(-500);
        tick();
        dac_ref = '0;
        check("loop_d0_neg", dout(0), -500);
        tick();
        check("loop_d0_after", dout(0), 0);

        loop_sel = 2'b00;
        drive(8200, 8300, 64, 64);
        repeat (6) tick();
        check("precal_data0", dout(0), 8);
        check("precal_data1", dout(1), 108);

        // Calibration: one-cycle request.
        cal_start = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            tick();
            cal_start = 1'b0;
            rec(j);
        end
        busy_cnt = 0; done_cnt = 0; vld_cnt = 0;
        for (int j = 1; j <= 30; j++) begin
            busy_cnt += int'(busy_a[j]);
            done_cnt += int'(done_a[j]);
            if (busy_a[j]) vld_cnt += int'(valid_a[j]);
        end
        check("cal_busy_len", busy_cnt, 21);
        check("cal_busy_start", 32'(busy_a[1]), 1);
        check("cal_busy_end", 32'(busy_a[22]), 0);
        check("cal_done_cnt", done_cnt, 1);
        check("cal_done_cyc", 32'(done_a[22]), 1);
        check("cal_valid_busy", vld_cnt, 0);
        check("cal_refill0", 32'(valid_a[22]), 0);
        check("cal_refill2", 32'(valid_a[24]), 0);
        check("cal_refill_end", 32'(valid_a[25]), 1);
        check("cal_data0", d0_a[25], 0);
        check("cal_data1", d1_a[25], 0);
        check("cal_off0", offv(0), 8200);
        check("cal_off1", offv(1), 8300);

        // Reset during ACCUM, with a stray request earlier in ACCUM.
        for (int j = 1; j <= 40; j++) begin
            cal_start = (j == 1) || (j == 8) || (j == 9);
            reset_n   = !((j == 13) || (j == 14));
            tick();
            rec(j);
            if (j == 13) begin
                check("abort_off0", offv(0), 8192);
                check("abort_off1", offv(1), 8192);
            end
        end
        cal_start = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int j = 1; j <= 40; j++) done_cnt += int'(done_a[j]);
        for (int j = 13; j <= 40; j++) busy_cnt += int'(busy_a[j]);
        check("abort_busy_pre", 32'(busy_a[12]), 1);
        check("abort_busy_post", busy_cnt, 0);
        check("abort_no_done", done_cnt, 0);
        check("abort_valid_4", 32'(valid_a[18]), 0);
        check("abort_valid_5", 32'(valid_a[19]), 1);
        check("abort_off_end0", offv(0), 8192);
        check("abort_off_end1", offv(1), 8192);

        // Request held high re-triggers straight after APPLY.
        cal_start = 1'b1;
        for (int j = 1; j <= 24; j++) begin
            tick();
            rec(j);
        end
        cal_start = 1'b0;
        check("retrig_busy1", 32'(busy_a[1]), 1);
        check("retrig_busy21", 32'(busy_a[21]), 1);
        check("retrig_gap", 32'(busy_a[22]), 0);
        check("retrig_done", 32'(done_a[22]), 1);
        check("retrig_again", 32'(busy_a[23]), 1);
        check("retrig_off0", offv(0), 8200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
